// File: rtl/mfp_conv_pkg.sv
// Shared state encoding and sizing helpers for the conv1d window path.
// Imported by the window generator and its shift register.
package mfp_conv_pkg;

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } conv_state_t;

  function automatic int half_of(input int kl);
    return (kl - 1) / 2;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mfp_win_shiftreg.sv
// KERNEL_L-deep pixel shift register; slot KERNEL_L-1 is newest.
// Either broadcasts din to every slot or shifts din in at the top.
module mfp_win_shiftreg
  import mfp_conv_pkg::*;
#(
  parameter int DataW    = 8,
  parameter int KERNEL_L = 5
) (
  input  logic                      clock,
  input  logic                      aclr,
  input  logic                      shift_en,
  input  logic                      load_all_en,
  input  logic [DataW-1:0]          din,
  output logic [DataW*KERNEL_L-1:0] win
);

  logic [DataW-1:0] sr [KERNEL_L];

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < KERNEL_L; i++)
        sr[i] <= '0;
    end else if (load_all_en) begin
      for (int i = 0; i < KERNEL_L; i++)
        sr[i] <= din;
    end else if (shift_en) begin
      for (int i = 0; i < KERNEL_L - 1; i++)
        sr[i] <= sr[i+1];
      sr[KERNEL_L-1] <= din;
    end
  end

  for (genvar g = 0; g < KERNEL_L; g++) begin : g_pack
    assign win[g*DataW +: DataW] = sr[g];
  end

endmodule

// File: rtl/mfp_conv1d_window.sv
// Streaming 1-D window generator with clamp padding at line edges.
// Feeds the parallel MAC one KERNEL_L-tap window per output pixel.
module mfp_conv1d_window
  import mfp_conv_pkg::*;
#(
  parameter int DataW    = 8,
  parameter int KERNEL_L = 5,
  parameter int LINE_W   = 640
) (
  input  logic                      clock,
  input  logic                      aclr,
  input  logic [DataW-1:0]          in_pix,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DataW*KERNEL_L-1:0] out_win,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sol,
  output logic                      out_eol
);

  localparam int HALF = half_of(KERNEL_L);
  localparam int CW   = clog2w(LINE_W);
  localparam int FW   = clog2w((HALF > 1) ? HALF : 1);

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [CW-1:0] COL_HALF = CW'(HALF);
  localparam logic [FW-1:0] FL_LAST  =
    FW'((HALF > 0) ? HALF - 1 : 0);

  conv_state_t      state;
  logic [CW-1:0]    in_col;
  logic [CW-1:0]    out_col;
  logic [FW-1:0]    fl_cnt;
  logic             adv;
  logic             accept;
  logic             emit;
  logic             flushing;
  logic             load_all;
  logic             shift;
  logic [DataW-1:0] newest;
  logic [DataW-1:0] din;

  assign adv      = !out_valid || out_ready;
  assign flushing = (state == FLUSH);
  assign in_ready = adv && !flushing;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;
  assign load_all = accept && (state == PRIME);
  assign shift    = (accept && (state == STREAM))
                  || (adv && flushing);

  // Right-edge replicate re-shifts the newest pixel.
  assign newest = out_win[(KERNEL_L-1)*DataW +: DataW];
  assign din    = flushing ? newest : in_pix;

  assign out_sol = out_valid && (out_col == '0);
  assign out_eol = out_valid && (out_col == COL_LAST);

  mfp_win_shiftreg #(
    .DataW    (DataW),
    .KERNEL_L (KERNEL_L)
  ) u_sr (
    .clock       (clock),
    .aclr        (aclr),
    .shift_en    (shift),
    .load_all_en (load_all),
    .din         (din),
    .win         (out_win)
  );

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state     <= PRIME;
      in_col    <= '0;
      fl_cnt    <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        PRIME: begin
          if (accept) begin
            out_valid <= (HALF == 0);
            if (LINE_W == 1) begin
              in_col <= '0;
              state  <= PRIME;
            end else begin
              in_col <= CW'(1);
              state  <= STREAM;
            end
          end else if (adv) begin
            out_valid <= 1'b0;
          end
        end
        STREAM: begin
          if (accept) begin
            out_valid <= (in_col >= COL_HALF);
            if (in_col == COL_LAST) begin
              in_col <= '0;
              state  <= (HALF > 0) ? FLUSH : PRIME;
            end else begin
              in_col <= in_col + 1'b1;
            end
          end else if (adv) begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          if (adv) begin
            out_valid <= 1'b1;
            if (fl_cnt == FL_LAST) begin
              fl_cnt <= '0;
              state  <= PRIME;
            end else begin
              fl_cnt <= fl_cnt + 1'b1;
            end
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      out_col <= '0;
    end else if (emit) begin
      out_col <= (out_col == COL_LAST) ? '0 : out_col + 1'b1;
    end
  end

endmodule

// File: tb/tb_mfp_conv1d_window.sv
// Scoreboard bench for mfp_conv1d_window over three configurations.
// ch0: K=5 W=8, ch1: K=1 W=4, ch2: K=5 W=3.
module tb_mfp_conv1d_window;

  typedef struct {
    logic [39:0] win;
    logic        sol;
    logic        eol;
  } exp_t;

  typedef logic [7:0] line_t [$];

  logic clock = 1'b0;
  logic aclr  = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb [$];

  logic [2:0][7:0]  pix;
  logic [2:0]       vld;
  logic [2:0]       rdy;
  logic [2:0]       ov;
  logic [2:0]       sol;
  logic [2:0]       eol;
  logic [2:0][39:0] win;
  logic             a_or = 1'b1;
  bit               bp_en = 1'b0;

  int kk [3] = '{5, 1, 5};

  assign win[1][39:8] = '0;

  mfp_conv1d_window #(
    .DataW(8), .KERNEL_L(5), .LINE_W(8)
  ) dut_a (
    .clock(clock), .aclr(aclr),
    .in_pix(pix[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .out_win(win[0]),
    .out_valid(ov[0]), .out_ready(a_or),
    .out_sol(sol[0]), .out_eol(eol[0])
  );

  mfp_conv1d_window #(
    .DataW(8), .KERNEL_L(1), .LINE_W(4)
  ) dut_b (
    .clock(clock), .aclr(aclr),
    .in_pix(pix[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .out_win(win[1][7:0]),
    .out_valid(ov[1]), .out_ready(1'b1),
    .out_sol(sol[1]), .out_eol(eol[1])
  );

  mfp_conv1d_window #(
    .DataW(8), .KERNEL_L(5), .LINE_W(3)
  ) dut_c (
    .clock(clock), .aclr(aclr),
    .in_pix(pix[2]), .in_valid(vld[2]),
    .in_ready(rdy[2]), .out_win(win[2]),
    .out_valid(ov[2]), .out_ready(1'b1),
    .out_sol(sol[2]), .out_eol(eol[2])
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // Clamp-padded reference window for column j.
  function automatic exp_t model(input line_t ln,
                                 input int k,
                                 input int j);
    exp_t e;
    int   h;
    int   c;
    int   lw;
    h = (k - 1) / 2;
    lw = ln.size();
    e.win = '0;
    for (int i = 0; i < k; i++) begin
      c = j - h + i;
      if (c < 0) c = 0;
      if (c > lw - 1) c = lw - 1;
      e.win[i*8 +: 8] = ln[c];
    end
    e.sol = (j == 0);
    e.eol = (j == lw - 1);
    return e;
  endfunction

  function automatic line_t rand_line(input int n);
    line_t q;
    for (int i = 0; i < n; i++)
      q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  int starts [$];
  int acc2 = -1;
  int first_emit = -1;
  int last_emit = -1;
  int rdy_low = 0;
  int act = 0;
  bit cnt_en = 1'b0;

  task automatic send(input int ch, input line_t ln);
    for (int j = 0; j < ln.size(); j++)
      sb.push_back(model(ln, kk[ch], j));
    for (int j = 0; j < ln.size(); j++) begin
      int t;
      bit got;
      t = 0;
      got = 1'b0;
      vld[ch] = 1'b1;
      pix[ch] = ln[j];
      while (!got && t < 200) begin
        @(negedge clock);
        got = rdy[ch];
        if (got && j == 0) starts.push_back(cyc);
        if (got && j == 2) acc2 = cyc;
        @(posedge clock);
        #1;
        t++;
      end
      check("accept", 64'(got), 64'(1));
    end
    vld[ch] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clock);
      t++;
    end
    check("drain", 64'(sb.size()), 64'(0));
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      a_or = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pops, stall stability, in_ready under stall.
  initial begin
    logic [41:0] hold [3];
    bit          stall [3];
    logic        orr;
    exp_t        e;
    for (int ch = 0; ch < 3; ch++) stall[ch] = 1'b0;
    forever begin
      @(negedge clock);
      for (int ch = 0; ch < 3; ch++) begin
        orr = (ch == 0) ? a_or : 1'b1;
        if (aclr) begin
          stall[ch] = 1'b0;
        end else begin
          if (stall[ch])
            check("hold", 64'({sol[ch], eol[ch], win[ch]}),
                  64'(hold[ch]));
          if (ov[ch] && !orr)
            check("rdy_stall", 64'(rdy[ch]), 64'(0));
          stall[ch] = ov[ch] && !orr;
          hold[ch] = {sol[ch], eol[ch], win[ch]};
          if (ov[ch] && orr) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("win", 64'(win[ch]), 64'(e.win));
              check("sol", 64'(sol[ch]), 64'(e.sol));
              check("eol", 64'(eol[ch]), 64'(e.eol));
            end
            if (first_emit < 0) first_emit = cyc;
            last_emit = cyc;
          end
          if (cnt_en && ch == act && !rdy[ch]) rdy_low++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    line_t l1;
    line_t l2;
    vld = '0;
    pix = '0;
    repeat (2) @(posedge clock);
    #1;
    for (int ch = 0; ch < 3; ch++) begin
      check("rst_valid", 64'(ov[ch]), 64'(0));
      check("rst_win", 64'(win[ch]), 64'(0));
      check("rst_sol", 64'(sol[ch]), 64'(0));
      check("rst_eol", 64'(eol[ch]), 64'(0));
      check("rst_ready", 64'(rdy[ch]), 64'(1));
    end
    aclr = 1'b0;
    @(posedge clock);
    #1;

    // basic line, first window one cycle after pixel 2
    l1 = '{8'd10, 8'd20, 8'd30, 8'd40,
           8'd50, 8'd60, 8'd70, 8'd80};
    first_emit = -1;
    send(0, l1);
    drain();
    check("lat_basic", 64'(first_emit - acc2), 64'(1));

    // two lines back to back
    act = 0;
    starts.delete();
    rdy_low = 0;
    cnt_en = 1'b1;
    l1 = rand_line(8);
    l2 = rand_line(8);
    send(0, l1);
    send(0, l2);
    drain();
    cnt_en = 1'b0;
    check("b2b_ready_low", 64'(rdy_low), 64'(4));
    check("b2b_gap", 64'(starts[1] - starts[0]), 64'(10));
    check("b2b_total", 64'(last_emit - starts[0]), 64'(20));

    // random backpressure
    bp_en = 1'b1;
    for (int r = 0; r < 3; r++) send(0, rand_line(8));
    drain();
    bp_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // KERNEL_L = 1
    act = 1;
    starts.delete();
    first_emit = -1;
    rdy_low = 0;
    cnt_en = 1'b1;
    send(1, rand_line(4));
    send(1, rand_line(4));
    drain();
    cnt_en = 1'b0;
    check("k1_ready_low", 64'(rdy_low), 64'(0));
    check("k1_lat", 64'(first_emit - starts[0]), 64'(1));
    check("k1_total", 64'(last_emit - starts[0]), 64'(8));

    // LINE_W = 3 with HALF = 2
    act = 2;
    l1 = '{8'd11, 8'd22, 8'd33};
    send(2, l1);
    send(2, rand_line(3));
    drain();

    // aclr while fl_cnt is 1
    act = 0;
    send(0, rand_line(8));
    @(posedge clock);
    #1;
    aclr = 1'b1;
    #1;
    check("fl_rst_valid", 64'(ov[0]), 64'(0));
    check("fl_rst_win", 64'(win[0]), 64'(0));
    check("fl_rst_sol", 64'(sol[0]), 64'(0));
    check("fl_rst_eol", 64'(eol[0]), 64'(0));
    sb.delete();
    @(posedge clock);
    #1;
    check("fl_rst_ready", 64'(rdy[0]), 64'(1));
    aclr = 1'b0;
    @(posedge clock);
    #1;
    send(0, rand_line(8));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
